// File: rtl/i2s_tx_if.sv
// Player-side bus of the I2S transmitter: sample hand-off plus the frame
// position and serial line that the transmitter drives back.
interface i2s_tx_if #(
   parameter int SAMPLE_BITS   = 16,
   parameter int UNDERRUN_BITS = 16
);
   logic [SAMPLE_BITS-1:0]   sample_l;
   logic [SAMPLE_BITS-1:0]   sample_r;
   logic                     sample_valid;
   logic                     mute;
   logic [7:0]               m_sample_index;
   logic                     frame_start;
   logic                     bclk;
   logic                     lrclk;
   logic                     sdata;
   logic [UNDERRUN_BITS-1:0] underrun_count;

   modport master (
      output sample_l, sample_r, sample_valid, mute,
      input  m_sample_index, frame_start, bclk, lrclk, sdata, underrun_count
   );

   modport slave (
      input  sample_l, sample_r, sample_valid, mute,
      output m_sample_index, frame_start, bclk, lrclk, sdata, underrun_count
   );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: a free-running 8-bit frame counter paces capture
// and serialisation; BCLK = mclk/4, LRCLK = mclk/256, 32-bit slots.
module i2s_tx #(
   parameter int SAMPLE_BITS   = 16,
   parameter int UNDERRUN_BITS = 16
) (
   input logic   mclk,
   input logic   rst,
   i2s_tx_if.slave bus
);
   logic [7:0]               idx;
   logic [7:0]               nxt;
   logic [4:0]               slot;
   logic                     chan;
   logic [SAMPLE_BITS-1:0]   hold_l;
   logic [SAMPLE_BITS-1:0]   hold_r;
   logic [SAMPLE_BITS-1:0]   word;
   logic [UNDERRUN_BITS-1:0] ucnt;
   logic                     sd;
   logic                     nbit;

   // Decode the slot about to be presented, so sdata changes with bclk falling.
   assign nxt  = idx + 8'd1;
   assign slot = nxt[6:2];
   assign chan = nxt[7];
   assign word = chan ? hold_r : hold_l;

   always_comb begin
      nbit = 1'b0;
      for (int k = 0; k < SAMPLE_BITS; k++)
         if (int'(slot) == SAMPLE_BITS - k) nbit = word[k];
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         idx    <= 8'd0;
         sd     <= 1'b0;
         hold_l <= '0;
         hold_r <= '0;
         ucnt   <= '0;
      end else begin
         idx <= nxt;
         if (idx == 8'hFF) begin
            if (bus.mute) begin
               hold_l <= '0;
               hold_r <= '0;
            end else if (bus.sample_valid) begin
               hold_l <= bus.sample_l;
               hold_r <= bus.sample_r;
            end else begin
               hold_l <= '0;
               hold_r <= '0;
               if (ucnt != '1) ucnt <= ucnt + 1'b1;
            end
         end
         // Slot 0 of a new frame decodes to 0, so swapping words at 255 never tears.
         if (idx[1:0] == 2'b11) sd <= nbit;
      end
   end

   assign bus.m_sample_index = idx;
   assign bus.frame_start    = (idx == 8'd0);
   assign bus.bclk           = idx[1];
   assign bus.lrclk          = idx[7];
   assign bus.sdata          = sd;
   assign bus.underrun_count = ucnt;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model of the I2S
// stream, directed phases plus randomized frames, and a 2-bit counter instance.
module tb_i2s_tx;
   logic mclk = 1'b0;
   logic rst;
   logic rst2;
   always #5 mclk = ~mclk;

   i2s_tx_if #(.SAMPLE_BITS(16), .UNDERRUN_BITS(16)) bus ();
   i2s_tx_if #(.SAMPLE_BITS(16), .UNDERRUN_BITS(2))  bus2 ();

   i2s_tx #(.SAMPLE_BITS(16), .UNDERRUN_BITS(16)) dut  (.mclk(mclk), .rst(rst),  .bus(bus));
   i2s_tx #(.SAMPLE_BITS(16), .UNDERRUN_BITS(2))  dut2 (.mclk(mclk), .rst(rst2), .bus(bus2));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   int          m_idx  = 0;
   logic [15:0] m_l    = '0;
   logic [15:0] m_r    = '0;
   int          m_cnt  = 0;
   int          m_idx2 = 0;
   int          m_cnt2 = 0;
   logic        prev_bclk = 1'b0;
   logic        slot_bits [64];
   int          q2 [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Line value while the counter reads i: slot (i%128)/4 of channel i/128,
   // MSB first from slot 1; everything else is zero.
   function automatic logic exp_sd(input int i, input logic [15:0] l, input logic [15:0] r);
      int          k;
      logic [15:0] t;
      k = (i % 128) / 4;
      if (k < 1 || k > 16) return 1'b0;
      t = ((i >= 128) ? r : l) >> (16 - k);
      return t[0];
   endfunction

   task automatic step();
      @(posedge mclk);
      cyc++;
      if (rst) begin
         m_idx = 0; m_l = '0; m_r = '0; m_cnt = 0;
      end else begin
         if (m_idx == 255) begin
            if (bus.mute) begin
               m_l = '0; m_r = '0;
            end else if (bus.sample_valid) begin
               m_l = bus.sample_l; m_r = bus.sample_r;
            end else begin
               m_l = '0; m_r = '0;
               if (m_cnt < 65535) m_cnt++;
            end
         end
         m_idx = (m_idx + 1) % 256;
      end
      if (rst2) begin
         m_idx2 = 0; m_cnt2 = 0;
      end else begin
         if (m_idx2 == 255 && m_cnt2 < 3) m_cnt2++;
         m_idx2 = (m_idx2 + 1) % 256;
      end
      #1;
      chk("index",       32'(bus.m_sample_index), 32'(m_idx));
      chk("frame_start", 32'(bus.frame_start),    32'(m_idx == 0));
      chk("bclk",        32'(bus.bclk),           32'((m_idx / 2) % 2));
      chk("lrclk",       32'(bus.lrclk),          32'(m_idx / 128));
      chk("sdata",       32'(bus.sdata),          32'(exp_sd(m_idx, m_l, m_r)));
      chk("underrun",    32'(bus.underrun_count), 32'(m_cnt));
      chk("underrun2",   32'(bus2.underrun_count), 32'(m_cnt2));
      if (!rst2 && m_idx2 == 0) q2.push_back(int'(bus2.underrun_count));
      if (!prev_bclk && bus.bclk) slot_bits[m_idx / 4] = bus.sdata;
      prev_bclk = bus.bclk;
   endtask

   // One full frame from index 0, collecting sdata at bclk rise; optionally
   // rewrites sample_l mid-frame at index chg_idx.
   task automatic run_frame(input int chg_idx, input logic [15:0] chg_val,
                            output logic [15:0] l, output logic [15:0] r, output int nz);
      for (int s = 0; s < 64; s++) slot_bits[s] = 1'b0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (chg_idx >= 0 && m_idx == chg_idx) bus.sample_l = chg_val;
      end
      nz = 0;
      for (int s = 0; s < 32; s++) begin
         if (s >= 1 && s <= 16) begin
            l[16 - s] = slot_bits[s];
            r[16 - s] = slot_bits[32 + s];
         end else begin
            nz += int'(slot_bits[s]) + int'(slot_bits[32 + s]);
         end
      end
   endtask

   initial begin
      logic [15:0] fl, fr, rl, rr, el, er;
      int          nz, cap, first, guard, v, mu;

      rst = 1'b1; rst2 = 1'b1;
      bus.sample_l = '0; bus.sample_r = '0; bus.sample_valid = 1'b0; bus.mute = 1'b0;
      bus2.sample_l = '0; bus2.sample_r = '0; bus2.sample_valid = 1'b0; bus2.mute = 1'b0;
      repeat (3) step();
      chk("rst_index", 32'(bus.m_sample_index), 32'd0);
      chk("rst_fs",    32'(bus.frame_start),    32'd1);
      chk("rst_sdata", 32'(bus.sdata),          32'd0);
      rst = 1'b0; rst2 = 1'b0;

      // idle: two frames with nothing valid
      step();
      chk("first_index", 32'(bus.m_sample_index), 32'd1);
      repeat (511) step();
      chk("idle_underrun", 32'(bus.underrun_count), 32'd2);

      bus.sample_l = 16'h8001; bus.sample_r = 16'h0001; bus.sample_valid = 1'b1;
      run_frame(-1, '0, fl, fr, nz);
      chk("idle_frame_l", 32'(fl), 32'd0);
      chk("idle_frame_r", 32'(fr), 32'd0);
      run_frame(100, 16'hFFFF, fl, fr, nz);
      chk("pat_l", 32'(fl), 32'h8001);
      chk("pat_r", 32'(fr), 32'h0001);
      chk("pat_zero_slots", 32'(nz), 32'd0);

      bus.mute = 1'b1; bus.sample_l = 16'h7FFF; bus.sample_r = 16'h7FFF;
      run_frame(-1, '0, fl, fr, nz);
      chk("midchg_l", 32'(fl), 32'hFFFF);
      chk("midchg_r", 32'(fr), 32'h0001);
      bus.mute = 1'b0;
      run_frame(-1, '0, fl, fr, nz);
      chk("mute_l", 32'(fl), 32'd0);
      chk("mute_r", 32'(fr), 32'd0);
      chk("mute_nz", 32'(nz), 32'd0);
      chk("mute_underrun", 32'(bus.underrun_count), 32'd2);

      // randomized frames; the expected words are those presented at capture
      el = bus.sample_l; er = bus.sample_r;
      for (int f = 0; f < 8; f++) begin
         rl = 16'($urandom); rr = 16'($urandom);
         v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         mu = ($urandom_range(0, 5) == 0) ? 1 : 0;
         bus.sample_l = rl; bus.sample_r = rr;
         bus.sample_valid = 1'(v); bus.mute = 1'(mu);
         run_frame(-1, '0, fl, fr, nz);
         chk("rand_prev_l", 32'(fl), 32'(el));
         chk("rand_prev_r", 32'(fr), 32'(er));
         el = (mu == 0 && v != 0) ? rl : 16'd0;
         er = (mu == 0 && v != 0) ? rr : 16'd0;
      end
      run_frame(-1, '0, fl, fr, nz);
      chk("rand_last_l", 32'(fl), 32'(el));
      chk("rand_last_r", 32'(fr), 32'(er));

      // reset in the middle of the left word
      bus.sample_l = 16'h8001; bus.sample_r = 16'h0001; bus.sample_valid = 1'b1; bus.mute = 1'b0;
      guard = 0;
      while (m_idx != 70 && guard < 300) begin step(); guard++; end
      chk("reach_70", 32'(m_idx), 32'd70);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_index", 32'(bus.m_sample_index), 32'd0);
      chk("midrst_sdata", 32'(bus.sdata), 32'd0);
      chk("midrst_under", 32'(bus.underrun_count), 32'd0);
      cap = -1; first = -1; guard = 0;
      while (first < 0 && guard < 600) begin
         step(); guard++;
         if (m_idx == 0 && cap < 0) cap = cyc;
         if (bus.sdata === 1'b1 && first < 0) first = cyc;
      end
      chk("rst_first_bit_found", 32'(first >= 0), 32'd1);
      chk("rst_first_bit_lat",   32'(first - cap), 32'd4);

      chk("sat_frames", 32'(q2.size() >= 5), 32'd1);
      if (q2.size() >= 5) begin
         chk("sat0", 32'(q2[0]), 32'd1);
         chk("sat1", 32'(q2[1]), 32'd2);
         chk("sat2", 32'(q2[2]), 32'd3);
         chk("sat3", 32'(q2[3]), 32'd3);
         chk("sat4", 32'(q2[4]), 32'd3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio output stage that sits directly downstream of `player_module`. It owns the frame counter `m_sample_index` that paces the player. Once per frame it captures one left/right sample pair and shifts it out as a Philips I2S stream: BCLK = mclk/4, LRCLK = mclk/256, 32 bit slots per channel. It also reports frames in which no sample was available.

## Interface
Parameters:
- `SAMPLE_BITS`, default 16: width of each channel word, MSB-first, two's complement. Legal range 1..31.
- `UNDERRUN_BITS`, default 16: width of the saturating underrun counter.

Ports:
- `mclk`  in  1: master clock, 256x sample rate; the only clock. All logic is on `posedge mclk`.
- `rst`  in  1: reset. Synchronous and active-high.
- `sample_l`  in  `SAMPLE_BITS`: left word. Sampled only at the capture edge.
- `sample_r`  in  `SAMPLE_BITS`: right word. Sampled only at the capture edge.
- `sample_valid`  in  1: the words are valid at the capture edge.
- `mute`  in  1: forces the captured words to 0.
- `m_sample_index`  out  8: free-running frame position, 0..255.
- `frame_start`  out  1: high while `m_sample_index == 0`.
- `bclk`  out  1: bit clock, equal to `m_sample_index[1]`.
- `lrclk`  out  1: word select, equal to `m_sample_index[7]`. 0 = left, 1 = right.
- `sdata`  out  1: serial data, registered.
- `underrun_count`  out  `UNDERRUN_BITS`: saturating count of frames captured with `sample_valid` low.

## Operation
Frame counter:
- `m_sample_index` increments by 1 every `mclk` and wraps 255 -> 0.
- `bclk`, `lrclk` and `frame_start` are direct bit/decode taps of this register. They are glitch-free.

Capture, at the edge where `m_sample_index == 255`:
- If `mute` is high: both holding words load 0. `underrun_count` is unchanged.
- Else if `sample_valid` is high: the holding words load `sample_l` and `sample_r`.
- Else: both holding words load 0, and `underrun_count` increments. It saturates at all-ones.
- Inputs are ignored at every other edge.

Serialisation:
- Let n = `m_sample_index + 1` (mod 256). The slot is n[6:2] and the channel is n[7].
- At each edge where `m_sample_index[1:0] == 3`, `sdata` loads:
  - `word[SAMPLE_BITS - slot]` of the selected channel, for slot 1..`SAMPLE_BITS`;
  - 0 for every other slot, including slot 0.
- Result: `sdata` changes on the same edge that `bclk` falls. The MSB appears one BCLK after the LRCLK transition, which is standard I2S.
- Holding words are updated at index 255. The shift for slot 0 of the new frame loads 0. Slot 1 of the new frame uses the new left word, with no tearing.
- There is no state machine beyond the counter. Behaviour is fully determined by `m_sample_index` and the two holding words.

## Timing
Reset values (any cycle `rst` is high):
- `m_sample_index` = 0, `bclk` = 0, `lrclk` = 0, `frame_start` = 1.
- `sdata` = 0, holding words = 0, `underrun_count` = 0.

Reset mid-frame:
- Abandons the frame immediately.
- The first edge after `rst` falls shows index 1. No partial word is resumed. The first capture is at index 255 of that frame.

Latency, input to line:
- Capture edge (index 255) to left MSB on `sdata`: 4 `mclk` (valid while index 4..7).
- Right MSB is valid while index 132..135.
- LSB: left slot `SAMPLE_BITS`, right slot `SAMPLE_BITS` + 32.

Simultaneous events:
- `mute` outranks `sample_valid`.
- `rst` outranks everything.
- Counter saturation and capture in the same edge: count stays at max, and the data path is unaffected.

## Test plan
- Reset release, 512 cycles idle (`sample_valid` = 0) -> index wraps at 256. `bclk` period = 4 `mclk`. `lrclk` period = 256. `sdata` always 0. `underrun_count` = 2.
- `sample_l` = 0x8001, `sample_r` = 0x0001, `sample_valid` = 1 held -> next frame:
  - left slots 1..16 = 1,0,…,0,1;
  - right slots 1..16 = 0,…,0,1;
  - slots 0 and 17..31 = 0;
  - bits checked by sampling `sdata` at `bclk` rise.
- Change `sample_l` to 0xFFFF mid-frame (index 100) -> the current frame is unchanged, and the next frame shows 0xFFFF.
- `mute` = 1 with valid data 0x7FFF -> frame outputs all zero, and `underrun_count` does not increment.
- Assert `rst` at index 70 during left-word shift -> all outputs reset on that edge. After release, the first non-zero `sdata` bit occurs 4 `mclk` after the next index-255 capture.
- `UNDERRUN_BITS` = 2, 5 frames with no valid -> count reads 1, 2, 3, 3, 3.
